// File: rtl/wash_pkg.sv
// Shared types and constants for the wash sequencer.
//   state_t      : FSM state, encoded with the debug `phase` code
//   LD_*         : timer period-select codes driven on `load`
//   ACT_*        : bit positions inside the actuator vector
//   timed_state(): 1 for states that run the timer and therefore
//                  pulse tmr_R on entry
package wash_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FILL_W      = 4'd1,
    ST_WASH        = 4'd2,
    ST_DRAIN_W     = 4'd3,
    ST_FILL_R      = 4'd4,
    ST_RINSE       = 4'd5,
    ST_DRAIN_R     = 4'd6,
    ST_SPIN        = 4'd7,
    ST_DONE        = 4'd8,
    ST_ABORT_DRAIN = 4'd9
  } state_t;

  localparam logic [1:0] LD_FILL  = 2'b00;
  localparam logic [1:0] LD_WASH  = 2'b01;
  localparam logic [1:0] LD_RINSE = 2'b10;
  localparam logic [1:0] LD_SPIN  = 2'b11;

  localparam int ACT_FILL    = 0;
  localparam int ACT_DRAIN   = 1;
  localparam int ACT_AGITATE = 2;
  localparam int ACT_SPIN    = 3;
  localparam int ACT_W       = 4;

  function automatic logic timed_state(input state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/wash_phase_decode.sv
// Combinational state -> actuator / timer-period decode.
//   state : current FSM state code
//   act   : actuator vector (bit positions ACT_* from wash_pkg)
//   load  : timer period select for this state (LD_FILL when idle/done)
module wash_phase_decode
  import wash_pkg::*;
(
  input  logic [3:0]       state,
  output logic [ACT_W-1:0] act,
  output logic [1:0]       load
);

  always_comb begin
    act  = '0;
    load = LD_FILL;
    case (state_t'(state))
      ST_FILL_W, ST_FILL_R: begin
        act[ACT_FILL] = 1'b1;
      end
      ST_WASH: begin
        act[ACT_AGITATE] = 1'b1;
        load             = LD_WASH;
      end
      ST_RINSE: begin
        act[ACT_AGITATE] = 1'b1;
        load             = LD_RINSE;
      end
      ST_DRAIN_W, ST_DRAIN_R, ST_ABORT_DRAIN: begin
        act[ACT_DRAIN] = 1'b1;
      end
      ST_SPIN: begin
        act[ACT_SPIN]  = 1'b1;
        act[ACT_DRAIN] = 1'b1;
        load           = LD_SPIN;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wash_sequencer.sv
// Wash program controller: fill, wash, drain, fill, rinse, drain, spin,
// done. Drives the period select / restart / freeze of an external
// washer timer and consumes its per-period expiry flags.
// Ports:
//   clk, R (sync, active low)     start, abort, lid_closed  (panel)
//   Tf Tw Td Tr Ts (timer expiry) load, tmr_R, hold         (timer control)
//   fill_valve drain_pump agitate spin (actuators)
//   busy, done (1-cycle pulse), phase (state code, debug)
// Optional build macro: WASH_SEQ_DOUBLE_RINSE_EN runs the rinse
// (fill, rinse, drain) twice before spinning.
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int LD_W = 2
) (
  input  logic            clk,
  input  logic            R,
  input  logic            start,
  input  logic            abort,
  input  logic            lid_closed,
  input  logic            Tf,
  input  logic            Tw,
  input  logic            Td,
  input  logic            Tr,
  input  logic            Ts,
  output logic [LD_W-1:0] load,
  output logic            tmr_R,
  output logic            hold,
  output logic            fill_valve,
  output logic            drain_pump,
  output logic            agitate,
  output logic            spin,
  output logic            busy,
  output logic            done,
  output logic [3:0]      phase
);

  state_t           state_reg, state_next;
  logic             entry_reg, entry_next;
  logic             hold_reg, hold_next;
  logic             flags_ok;
  logic             can_abort;
  logic [ACT_W-1:0] act;
  logic [1:0]       dec_load;

`ifdef WASH_SEQ_DOUBLE_RINSE_EN
  logic rinse2_reg, rinse2_next;
`endif

  always_ff @(posedge clk) begin
    if (!R) begin
      state_reg <= ST_IDLE;
      entry_reg <= 1'b0;
      hold_reg  <= 1'b0;
`ifdef WASH_SEQ_DOUBLE_RINSE_EN
      rinse2_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      entry_reg <= entry_next;
      hold_reg  <= hold_next;
`ifdef WASH_SEQ_DOUBLE_RINSE_EN
      rinse2_reg <= rinse2_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    // Expiry flags count only once the timer has been restarted (not in
    // the entry cycle) and while it is actually running (not frozen).
    flags_ok   = lid_closed && !hold_reg && !entry_reg;
    can_abort  = abort && (state_reg == ST_FILL_W || state_reg == ST_WASH ||
                           state_reg == ST_FILL_R || state_reg == ST_RINSE);
`ifdef WASH_SEQ_DOUBLE_RINSE_EN
    rinse2_next = rinse2_reg;
`endif

    if (can_abort) begin
      state_next = ST_ABORT_DRAIN;
    end else begin
      case (state_reg)
        ST_IDLE:        if (start && lid_closed) state_next = ST_FILL_W;
        ST_FILL_W:      if (flags_ok && Tf)      state_next = ST_WASH;
        ST_WASH:        if (flags_ok && Tw)      state_next = ST_DRAIN_W;
        ST_DRAIN_W:     if (flags_ok && Td)      state_next = ST_FILL_R;
        ST_FILL_R:      if (flags_ok && Tf)      state_next = ST_RINSE;
        ST_RINSE:       if (flags_ok && Tr)      state_next = ST_DRAIN_R;
        ST_DRAIN_R: begin
          if (flags_ok && Td) begin
`ifdef WASH_SEQ_DOUBLE_RINSE_EN
            if (!rinse2_reg) begin
              state_next  = ST_FILL_R;
              rinse2_next = 1'b1;
            end else begin
              state_next = ST_SPIN;
            end
`else
            state_next = ST_SPIN;
`endif
          end
        end
        ST_SPIN:        if (flags_ok && Ts)      state_next = ST_DONE;
        ST_DONE:                                 state_next = ST_IDLE;
        ST_ABORT_DRAIN: if (flags_ok && Td)      state_next = ST_IDLE;
        default:                                 state_next = ST_IDLE;
      endcase
    end

`ifdef WASH_SEQ_DOUBLE_RINSE_EN
    if (state_reg == ST_IDLE || can_abort) rinse2_next = 1'b0;
`endif

    // A state change into a timed phase restarts the timer next cycle;
    // DRAIN_R -> FILL_R (double rinse) counts as a fresh entry too.
    entry_next = (state_next != state_reg) && timed_state(state_next);
    // The freeze follows the lid with one cycle of latency and is never
    // applied once the program falls back to IDLE.
    hold_next  = !lid_closed && (state_reg != ST_IDLE) &&
                 (state_next != ST_IDLE);
  end

  wash_phase_decode u_decode (
    .state (state_reg),
    .act   (act),
    .load  (dec_load)
  );

  assign load       = LD_W'(dec_load);
  assign tmr_R      = (state_reg == ST_IDLE) || entry_reg;
  assign hold       = hold_reg;
  assign fill_valve = act[ACT_FILL]    && !hold_reg;
  assign drain_pump = act[ACT_DRAIN]   && !hold_reg;
  assign agitate    = act[ACT_AGITATE] && !hold_reg;
  assign spin       = act[ACT_SPIN]    && !hold_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign done       = (state_reg == ST_DONE);
  assign phase      = state_reg;

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed bench for wash_sequencer with a small behavioural timer that
// raises the flags of the selected period 5 unheld cycles after restart.
module tb_wash_sequencer;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       lid_closed = 1'b1;
  logic       Tf, Tw, Td, Tr, Ts;
  logic [1:0] load;
  logic       tmr_R, hold, fill_valve, drain_pump, agitate, spin, busy, done;
  logic [3:0] phase;

  logic frc_tf = 1'b0, frc_td = 1'b0, frc_ts = 1'b0;
  int   tcnt = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pulses  = 0;
  int done_cnt = 0;
  int hold_cnt = 0;
  int agit_cnt = 0;
  int last_phase = 0;
  int ph_log[$];
  int ld_log[$];
  int t0;

`ifdef WASH_SEQ_DOUBLE_RINSE_EN
  localparam int NPH = 12;
  localparam int NLD = 10;
  int exp_ph[NPH] = '{1, 2, 3, 4, 5, 6, 4, 5, 6, 7, 8, 0};
  int exp_ld[NLD] = '{0, 1, 0, 0, 2, 0, 0, 2, 0, 3};
`else
  localparam int NPH = 9;
  localparam int NLD = 7;
  int exp_ph[NPH] = '{1, 2, 3, 4, 5, 6, 7, 8, 0};
  int exp_ld[NLD] = '{0, 1, 0, 0, 2, 0, 3};
`endif

  wash_sequencer #(.LD_W(2)) dut (
    .clk        (clk),
    .R          (R),
    .start      (start),
    .abort      (abort),
    .lid_closed (lid_closed),
    .Tf         (Tf),
    .Tw         (Tw),
    .Td         (Td),
    .Tr         (Tr),
    .Ts         (Ts),
    .load       (load),
    .tmr_R      (tmr_R),
    .hold       (hold),
    .fill_valve (fill_valve),
    .drain_pump (drain_pump),
    .agitate    (agitate),
    .spin       (spin),
    .busy       (busy),
    .done       (done),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  // Timer model: restart on tmr_R, freeze on hold, expire at count 4.
  always @(posedge clk) begin
    if (tmr_R)                 tcnt <= 0;
    else if (!hold && tcnt < 15) tcnt <= tcnt + 1;
  end

  wire expired = (tcnt >= 4);
  assign Tf = (expired && load == 2'd0) || frc_tf;
  assign Td = (expired && load == 2'd0) || frc_td;
  assign Tw =  expired && load == 2'd1;
  assign Tr =  expired && load == 2'd2;
  assign Ts = (expired && load == 2'd3) || frc_ts;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic clear_logs();
    pulses = 0; done_cnt = 0; hold_cnt = 0; agit_cnt = 0;
    ph_log.delete();
    ld_log.delete();
  endtask

  // Advance one cycle and log DUT outputs mid-cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (int'(phase) != last_phase) begin
      ph_log.push_back(int'(phase));
      last_phase = int'(phase);
    end
    if (busy && tmr_R) begin
      pulses++;
      ld_log.push_back(int'(load));
    end
    if (done)    done_cnt++;
    if (hold)    hold_cnt++;
    if (agitate) agit_cnt++;
  endtask

  task automatic wait_phase(input int p, input int maxc, input string tag);
    int n = 0;
    while (int'(phase) != p && n < maxc) begin
      tick();
      n++;
    end
    check(tag, int'(phase), p);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_tmr_R", tmr_R, 1);
    check("rst_busy", busy, 0);
    check("rst_phase", phase, 0);
    check("rst_load", load, 0);
    check("rst_fill", fill_valve, 0);
    check("rst_drain", drain_pump, 0);
    check("rst_agit", agitate, 0);
    check("rst_spin", spin, 0);
    check("rst_done", done, 0);
    check("rst_hold", hold, 0);
    R = 1'b1;
    tick();

    // Nominal run
    clear_logs();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_phase(0, 300, "nom_end_idle");
    check("nom_phase_count", ph_log.size(), NPH);
    for (int i = 0; i < NPH; i++)
      check($sformatf("nom_phase[%0d]", i), (i < ph_log.size()) ? ph_log[i] : -1, exp_ph[i]);
    check("nom_tmr_pulses", pulses, NLD);
    for (int i = 0; i < NLD; i++)
      check($sformatf("nom_load[%0d]", i), (i < ld_log.size()) ? ld_log[i] : -1, exp_ld[i]);
    check("nom_done_cycles", done_cnt, 1);

    // Lid opened for 10 cycles mid-WASH
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_phase(2, 50, "lid_wash_entry");
    t0 = cyc;
    clear_logs();
    tick();
    check("lid_agit_before", agitate, 1);
    lid_closed = 1'b0;
    repeat (10) tick();
    lid_closed = 1'b1;
    wait_phase(3, 100, "lid_reach_drain");
    check("lid_wash_cycles", cyc - t0, 16);
    check("lid_hold_cycles", hold_cnt, 10);
    check("lid_agit_unheld", agit_cnt, 5);
    check("lid_tmr_pulses", pulses, 1);
    wait_phase(0, 300, "lid_end_idle");

    // Abort in RINSE
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_phase(5, 200, "abt_rinse");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abt_phase", phase, 9);
    check("abt_tmr_R", tmr_R, 1);
    check("abt_load", load, 0);
    check("abt_drain", drain_pump, 1);
    check("abt_agit", agitate, 0);
    wait_phase(0, 30, "abt_end_idle");

    // Spurious flags in FILL_W
    start = 1'b1;
    frc_tf = 1'b1;
    tick();
    start = 1'b0;
    check("spur_fill_entry", phase, 1);
    tick();
    frc_tf = 1'b0;
    check("spur_tf_entry_ignored", phase, 1);
    frc_ts = 1'b1;
    frc_td = 1'b1;
    tick(); tick();
    frc_ts = 1'b0;
    frc_td = 1'b0;
    check("spur_ts_td_ignored", phase, 1);
    check("spur_fill_valve", fill_valve, 1);

    // Reset during SPIN
    wait_phase(7, 200, "rst_reach_spin");
    check("spin_motor", spin, 1);
    R = 1'b0;
    tick();
    R = 1'b1;
    check("rspin_phase", phase, 0);
    check("rspin_tmr_R", tmr_R, 1);
    check("rspin_spin", spin, 0);
    check("rspin_drain", drain_pump, 0);
    check("rspin_busy", busy, 0);

    // Start with lid open is ignored
    lid_closed = 1'b0;
    start = 1'b1;
    repeat (3) tick();
    check("lidopen_start_phase", phase, 0);
    check("lidopen_start_busy", busy, 0);
    start = 1'b0;
    lid_closed = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
